// File: rtl/bus_arbiter_if.sv
// Shared IO_bus arbitration interface: per-master request/handshake lanes plus
// the single downstream slave-bus handshake. The arbiter uses the slave view;
// the master view is the side the bus masters and the IO_bus slaves drive from.
interface bus_arbiter_if #(
    parameter int NOS_MASTERS = 2
);
    logic [NOS_MASTERS-1:0]    m_req;
    logic [NOS_MASTERS-1:0]    m_grant;
    logic [NOS_MASTERS-1:0]    m_handshake_1;
    logic [32*NOS_MASTERS-1:0] m_data_out;
    logic [NOS_MASTERS-1:0]    m_RW;
    logic [NOS_MASTERS-1:0]    m_handshake_2;
    logic [NOS_MASTERS-1:0]    m_error;
    logic                      bus_handshake_1;
    logic                      bus_handshake_2;
    logic [31:0]               bus_data_out;
    logic                      bus_RW;
    logic                      busy;

    modport slave (
        input  m_req, m_handshake_1, m_data_out, m_RW, bus_handshake_2,
        output m_grant, m_handshake_2, m_error, bus_handshake_1, bus_data_out,
               bus_RW, busy
    );

    modport master (
        output m_req, m_handshake_1, m_data_out, m_RW, bus_handshake_2,
        input  m_grant, m_handshake_2, m_error, bus_handshake_1, bus_data_out,
               bus_RW, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 32-bit IO_bus. Grants one master at a
// time, forwards its command word and handshake_1 to the slave bus, routes
// handshake_2 back to the owner only, and aborts a transaction the slave
// never acknowledges. All outputs are registered.
module bus_arbiter #(
    parameter int NOS_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    localparam int IW = (NOS_MASTERS > 1) ? $clog2(NOS_MASTERS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_GRANT        = 3'd1;
    localparam logic [2:0] S_WAIT_ACK     = 3'd2;
    localparam logic [2:0] S_ABORT        = 3'd3;
    localparam logic [2:0] S_WAIT_RELEASE = 3'd4;

    logic [2:0]             state_q;
    logic [NOS_MASTERS-1:0] grant_q;
    logic [IW-1:0]          owner_q;
    logic [IW-1:0]          last_grant_q;
    logic                   hs1_q;
    logic [NOS_MASTERS-1:0] hs2_q;
    logic [NOS_MASTERS-1:0] error_q;
    logic [31:0]            data_q;
    logic                   rw_q;
    logic                   busy_q;
    logic [CW-1:0]          count_q;
    logic                   acked_q;

    // Owner's lanes, selected by the registered owner index.
    logic        own_req;
    logic        own_hs1;
    logic        own_rw;
    logic [31:0] own_data;

    assign own_req  = bus.m_req[owner_q];
    assign own_hs1  = bus.m_handshake_1[owner_q];
    assign own_rw   = bus.m_RW[owner_q];
    assign own_data = bus.m_data_out[32*owner_q +: 32];

    // Round-robin pick: first requester strictly after last_grant, cyclic.
    logic                   found;
    logic [IW-1:0]          winner;
    logic [NOS_MASTERS-1:0] winner_onehot;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // so no path leaves a value held and no latch is inferred.
        found         = 1'b0;
        winner        = last_grant_q;
        winner_onehot = '0;
        for (int k = 1; k <= NOS_MASTERS; k++) begin
            int cand;
            cand = (int'(last_grant_q) + k) % NOS_MASTERS;
            if (!found && bus.m_req[cand]) begin
                found  = 1'b1;
                winner = IW'(cand);
            end
        end
        if (found) begin
            winner_onehot[winner] = 1'b1;
        end
    end

    // Arbitration FSM with registered bus/master outputs and timeout counter.
    always_ff @(posedge clk) begin
        // NOTE: state and outputs use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_grant_q <= IW'(NOS_MASTERS - 1);
            hs1_q        <= 1'b0;
            hs2_q        <= '0;
            error_q      <= '0;
            data_q       <= '0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            count_q      <= '0;
            acked_q      <= 1'b0;
        end else begin
            hs2_q   <= '0;
            error_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        grant_q      <= winner_onehot;
                        owner_q      <= winner;
                        last_grant_q <= winner;
                        busy_q       <= 1'b1;
                        state_q      <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    data_q <= own_data;
                    rw_q   <= own_rw;
                    if (!own_req) begin
                        hs1_q   <= 1'b0;
                        state_q <= S_WAIT_RELEASE;
                    end else if (own_hs1) begin
                        hs1_q   <= 1'b1;
                        count_q <= '0;
                        acked_q <= 1'b0;
                        state_q <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    data_q          <= own_data;
                    rw_q            <= own_rw;
                    hs1_q           <= own_hs1 & own_req;
                    hs2_q[owner_q]  <= bus.bus_handshake_2;
                    if (bus.bus_handshake_2) begin
                        acked_q <= 1'b1;
                    end
                    if (!hs1_q && !bus.bus_handshake_2) begin
                        state_q <= S_WAIT_RELEASE;
                    end else if (!acked_q && !bus.bus_handshake_2) begin
                        if (count_q == CNT_LAST) begin
                            hs1_q            <= 1'b0;
                            hs2_q            <= '0;
                            error_q[owner_q] <= 1'b1;
                            state_q          <= S_ABORT;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                S_ABORT: begin
                    hs1_q   <= 1'b0;
                    state_q <= S_WAIT_RELEASE;
                end
                S_WAIT_RELEASE: begin
                    hs1_q <= 1'b0;
                    if (!own_req && !bus.bus_handshake_2) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        data_q  <= '0;
                        rw_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_grant         = grant_q;
    assign bus.m_handshake_2   = hs2_q;
    assign bus.m_error         = error_q;
    assign bus.bus_handshake_1 = hs1_q;
    assign bus.bus_data_out    = data_q;
    assign bus.bus_RW          = rw_q;
    assign bus.busy            = busy_q;
endmodule
